generic_fifo_v2: RTL
====================

Name: generic_fifo_v2

Overview:
- Parametrised synchronous FIFO, the successor to the team's generic FIFO, used as the standard buffer between linked-list control blocks and their request/response streams.
- Uses all DEPTH entries, including non-power-of-2 depths.
- Adds simultaneous push/pop throughput, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- First-word-fall-through (FWFT) read port.

Parameters:
- DATA_WIDTH, 8, width of each entry in bits (>=1).
- DEPTH, 16, number of entries (>=2; power of 2 not required).
- AFULL_THRESH, DEPTH-2, fifo_almost_full asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 2, fifo_almost_empty asserts when count <= this value (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- fifo_data_in  in  DATA_WIDTH  write data.
- fifo_data_push  in  1  write request.
- fifo_data_pop  in  1  read request; consumes the entry currently on fifo_data_out.
- fifo_flush  in  1  synchronous clear of contents.
- err_clear  in  1  clears the sticky error flags.
- fifo_data_out  out  DATA_WIDTH  head entry (FWFT).
- fifo_data_out_vld  out  1  fifo_data_out holds valid data (equals !fifo_empty).
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_almost_full  out  1  count >= AFULL_THRESH.
- fifo_almost_empty  out  1  count <= AEMPTY_THRESH.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.
- fifo_overflow  out  1  sticky: a push was dropped.
- fifo_underflow  out  1  sticky: a pop hit an empty FIFO.

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - rd_ptr, wr_ptr and count go to 0; error flags go to 0.
  - Outputs after reset: empty=1, vld=0, full=0, almost_empty=1, almost_full=0, count=0.
  - Storage array is not reset; fifo_data_out is don't-care while vld=0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Every output is a decode of registered state only; no combinational path from inputs to outputs.
- Accept rules, evaluated each cycle:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok): a push while full is accepted when a pop is accepted in the same cycle.
- Accepted push: mem[wr_ptr] <= fifo_data_in; wr_ptr advances.
- Accepted pop: rd_ptr advances.
- Pointer wrap: when a pointer equals DEPTH-1 it wraps to 0; no modulo-2^n assumption.
- Count update: count +1 on push only; -1 on pop only; unchanged when both or neither are accepted.
- Push and pop accepted together: both take effect in that cycle (unlike the predecessor, where neither pointer moved).
- Latency:
  - A write into an empty FIFO appears on fifo_data_out with vld=1 on the cycle after the push edge.
  - After a pop edge, the next entry is presented in the following cycle.
- Push while full without pop: data dropped, state unchanged, fifo_overflow set.
- Pop while empty: no state change, fifo_underflow set. A push in that same cycle is still accepted.
- fifo_flush:
  - At the next edge: pointers and count go to 0.
  - Has priority over push/pop in the same cycle; those requests are ignored and raise no errors.
  - Error flags are unaffected.
- err_clear:
  - Clears both sticky flags at the next edge.
  - If an error event occurs in the same cycle, the set wins.

Decomposition:
- Package generic_fifo_pkg:
  - function fifo_cnt_width(depth) returning $clog2(depth+1).
  - Localparam helper for pointer width $clog2(DEPTH), minimum 1.
- Sub-module fifo_wrap_ptr (MAX parameter; inputs clk, reset, inc, clr; output ptr), instanced once for the read pointer and once for the write pointer.
- Storage, count, flags and error logic live in the top module.

Test Plan:
- Reset, then push 0x11..0x1F (15 words, DEPTH=16) -> count=15, full=0, almost_full=1; 16th push of 0x20 -> full=1, count=16.
- Fill to 16, push 0xAA with no pop -> overflow=1, count stays 16; pop all 16 -> data 0x11..0x20 in order; count reaches 0, empty=1.
- Full FIFO, push 0x55 with pop in the same cycle -> head 0x11 consumed, count stays 16, full stays 1; 0x55 is read last.
- DEPTH=5: push/pop 12 words in a stream with push and pop held continuously -> in-order data, pointers wrap 4->0, count stays at 1 throughout.
- Empty FIFO, pop asserted -> underflow=1; err_clear next cycle -> 0; err_clear with a simultaneous pop on empty -> underflow stays 1.
- Count=7, flush with push in the same cycle -> count=0, empty=1, no overflow/underflow. Reset asserted mid-stream -> outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/generic_fifo_pkg.sv
// Shared sizing helpers for the generic FIFO family.
// Occupancy counters and storage pointers are sized from these functions.
package generic_fifo_pkg;

  // The occupancy count must be able to hold DEPTH itself, so it needs depth+1 codes.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for indexing 0..depth-1. It is never narrower than one bit.
  function automatic int fifo_ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer that counts 0..MAX and then wraps to 0.
// The range does not have to be a power of two. A synchronous clear takes priority over increment.
module fifo_wrap_ptr #(
  parameter int MAX = 15,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == MAX_C) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/generic_fifo_v2.sv
// Parametrised synchronous FWFT FIFO using all DEPTH entries.
// Provides occupancy count, almost flags, synchronous flush and sticky overflow/underflow.
module generic_fifo_v2
  import generic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int CW           = fifo_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_data_push,
  input  logic                  fifo_data_pop,
  input  logic                  fifo_flush,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_data_out_vld,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [CW-1:0]         fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int            PW       = fifo_ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic                  ovf_q;
  logic                  unf_q;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Handshake: a pop is taken when the FIFO is not empty, which means fifo_data_out_vld is high.
  // A push is taken when the FIFO is not full, or when a pop is taken in the same cycle.
  // A flush overrides both requests, and requests dropped because of a flush are not counted as errors.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!fifo_flush) begin
      pop_ok  = fifo_data_pop & ~empty;
      push_ok = fifo_data_push & (~full | pop_ok);
      ovf_evt = fifo_data_push & ~push_ok;
      unf_evt = fifo_data_pop & empty;
    end
  end

  fifo_wrap_ptr #(
    .MAX (DEPTH - 1),
    .W   (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .clr   (fifo_flush),
    .ptr   (rd_ptr)
  );

  fifo_wrap_ptr #(
    .MAX (DEPTH - 1),
    .W   (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .clr   (fifo_flush),
    .ptr   (wr_ptr)
  );

  // The count is unchanged when a push and a pop are taken together, because they cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (fifo_flush) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count <= count - CW'(1);
    end
  end

  // The storage array is not reset. Its contents are only observed behind the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  // A new error event wins over err_clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end else if (err_clear) begin
        ovf_q <= 1'b0;
      end
      if (unf_evt) begin
        unf_q <= 1'b1;
      end else if (err_clear) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign fifo_data_out     = mem[rd_ptr];
  assign fifo_data_out_vld = ~empty;
  assign fifo_full         = full;
  assign fifo_empty        = empty;
  assign fifo_almost_full  = (count >= AFULL_C);
  assign fifo_almost_empty = (count <= AEMPTY_C);
  assign fifo_count        = count;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

endmodule
